insn_encoder_loader: RTL and testbench

// - Inverse of the control-unit instruction decoders: packs RV32I fields (fmt, opcode, rd, rs1, rs2, funct3, funct7, imm) into 32-bit words.
// - Streams encoded words into instruction memory at consecutive word addresses.
// - Used by bring-up benches and the boot path to load programs without an external assembler.

---
 rtl/insn_encoder_loader.sv | 94 +++++++++
 tb/tb_insn_encoder_loader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/insn_encoder_loader.sv
// insn_encoder_loader: packs RV32I fields into instruction words and streams them into memory; IMM_RANGE_CHECK_EN adds a sticky err output for unencodable immediates.
module insn_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int DEPTH = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      finish,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                fmt,
  input  logic [6:0]                opcode,
  input  logic [4:0]                rd,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  input  logic [2:0]                funct3,
  input  logic [6:0]                funct7,
  input  logic [31:0]               imm,
  output logic                      mem_we,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      done
`ifdef IMM_RANGE_CHECK_EN
  ,output logic                     err
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state, next;
  logic [31:0] enc;
  logic accept, write, bad;
  // Field packing per instruction format; reserved formats produce no word.
  always_comb begin
    enc = fmt == 3'd0 ? {funct7, rs2, rs1, funct3, rd, opcode} :
          fmt == 3'd1 ? {imm[11:0], rs1, funct3, rd, opcode} :
          fmt == 3'd2 ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
          fmt == 3'd3 ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
          fmt == 3'd4 ? {imm[31:12], rd, opcode} :
          fmt == 3'd5 ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} : 32'h0;
  end
`ifdef IMM_RANGE_CHECK_EN
  // An immediate fits when the bits above its sign bit all copy it, and branch/jump offsets are even.
  always_comb begin
    bad = (fmt == 3'd1 || fmt == 3'd2) ? !(&imm[31:11] || ~|imm[31:11]) :
          fmt == 3'd3 ? !(&imm[31:12] || ~|imm[31:12]) || imm[0] :
          fmt == 3'd4 ? |imm[11:0] :
          fmt == 3'd5 ? !(&imm[31:20] || ~|imm[31:20]) || imm[0] : 1'b0;
  end
`else
  assign bad = 1'b0;
`endif
  // Session sequencing and handshake; a beat is consumed whenever ready, but only valid formats write.
  always_comb begin
    next = state == IDLE ? (start ? ACTIVE : IDLE) :
           state == ACTIVE ? (finish ? DONE : ACTIVE) : IDLE;
    full = count == CW'(DEPTH);
    in_ready = state == ACTIVE && !full;
    done = state == DONE;
    accept = in_valid && in_ready;
    write = accept && fmt < 3'd6 && !bad;
  end
  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  // Write port, word counter and error flag; a new session clears the counter and error.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we <= 1'b0;
      mem_addr <= BASE_ADDR;
      mem_wdata <= 32'h0;
      count <= '0;
`ifdef IMM_RANGE_CHECK_EN
      err <= 1'b0;
`endif
    end else begin
      mem_we <= write;
      if (write) begin
        mem_addr <= BASE_ADDR + (32'(count) << 2);
        mem_wdata <= enc;
        count <= count + CW'(1);
      end
      if (state == IDLE && start) count <= '0;
`ifdef IMM_RANGE_CHECK_EN
      if (state == IDLE && start) err <= 1'b0;
      else if (accept && bad) err <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_insn_encoder_loader.sv
// tb_insn_encoder_loader: table vectors, corner sequences and random traffic checked against a session-level scoreboard.
module tb_insn_encoder_loader;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset, start, finish, in_valid, in_ready;
  logic [2:0] fmt, funct3;
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm, mem_addr, mem_wdata;
  logic mem_we, full, done;
  logic [2:0] count;
`ifdef IMM_RANGE_CHECK_EN
  logic err;
`endif
  insn_encoder_loader #(.BASE_ADDR(32'h0), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .done(done)
`ifdef IMM_RANGE_CHECK_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] f;
    logic [6:0] op;
    logic [4:0] d, s1, s2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] im;
    logic [31:0] w;
  } vec_t;
  vec_t tbl[8];
  int checks = 0, passed = 0;
  int m_state = 0, m_count = 0;
  logic m_we = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_data = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [31:0] enc(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d, s1, s2,
                                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w;
    w = 0;
    w[6:0] = op;
    w[14:12] = f3;
    w[19:15] = s1;
    w[24:20] = s2;
    w[11:7] = d;
    if (f == 0) w[31:25] = f7;
    if (f == 1) w[31:20] = im[11:0];
    if (f == 2) begin w[31:25] = im[11:5]; w[11:7] = im[4:0]; end
    if (f == 3) begin w[31] = im[12]; w[30:25] = im[10:5]; w[11:8] = im[4:1]; w[7] = im[11]; end
    if (f == 4) w[31:12] = im[31:12];
    if (f == 5) begin w[31] = im[20]; w[30:21] = im[10:1]; w[20] = im[11]; w[19:12] = im[19:12]; end
    if (f == 1 || f == 4 || f == 5) w[24:15] = (f == 1) ? {w[24:20], s1} : w[24:15];
    if (f == 4 || f == 5) w[19:15] = (f == 4) ? im[19:15] : im[19:15];
    if (f == 4) w[24:20] = im[24:20];
    if (f == 4 || f == 5) w[14:12] = im[14:12];
    if (f == 5) w[24:21] = im[4:1];
    return (f > 5) ? 32'h0 : w;
  endfunction
  function automatic bit imm_ok(input logic [2:0] f, input logic [31:0] im);
    int v;
    v = $signed(im);
    if (f == 1 || f == 2) return v >= -2048 && v < 2048;
    if (f == 3) return v >= -4096 && v < 4096 && im[0] == 0;
    if (f == 5) return v >= -(1 << 20) && v < (1 << 20) && im[0] == 0;
    if (f == 4) return im[11:0] == 0;
    return 1;
  endfunction
  task automatic set_f(input vec_t v);
    fmt = v.f; opcode = v.op; rd = v.d; rs1 = v.s1; rs2 = v.s2;
    funct3 = v.f3; funct7 = v.f7; imm = v.im;
  endtask
  task automatic rnd_fields(input int fmax);
    fmt = 3'($urandom_range(0, fmax));
    opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    funct3 = 3'($urandom); funct7 = 7'($urandom);
    case ($urandom_range(0, 2))
      0: imm = $urandom;
      1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      default: imm = $urandom & 32'hFFFF_F000;
    endcase
  endtask
  task automatic step(input bit rs, st, fn, v, input logic [31:0] ew);
    bit acc, ok;
    reset = rs; start = st; finish = fn; in_valid = v;
    chk("in_ready", in_ready, 32'(m_state == 1 && m_count < D));
    chk("done", done, 32'(m_state == 2));
    acc = v && m_state == 1 && m_count < D && !rs;
    ok = fmt < 6;
`ifdef IMM_RANGE_CHECK_EN
    if (acc && ok && !imm_ok(fmt, imm)) begin ok = 0; m_err = 1; end
`endif
    if (rs) begin
      m_state = 0; m_count = 0; m_we = 0; m_addr = 0; m_data = 0; m_err = 0;
    end else begin
      m_we = acc && ok;
      if (m_we) begin m_addr = 32'(4 * m_count); m_data = ew; m_count++; end
      if (m_state == 0 && st) begin m_state = 1; m_count = 0; m_err = 0; end
      else if (m_state == 1 && fn) m_state = 2;
      else if (m_state == 2) m_state = 0;
    end
    @(posedge clk); #1;
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_data);
    chk("count", count, 32'(m_count));
    chk("full", full, 32'(m_count == D));
`ifdef IMM_RANGE_CHECK_EN
    chk("err", err, m_err);
`endif
  endtask
  task automatic restart();
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
  endtask
  initial begin
    tbl[0] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF};
    tbl[1] = '{3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF00293};
    tbl[2] = '{3'd2, 7'h23, 5'd31, 5'd3, 5'd2, 3'd2, 7'd0, 32'd12, 32'h0021A623};
    tbl[3] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE000EE3};
    tbl[4] = '{3'd4, 7'h37, 5'd10, 5'd7, 5'd9, 3'd5, 7'd3, 32'h1234_5000, 32'h12345537};
    tbl[5] = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3};
    tbl[6] = '{3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0};
    tbl[7] = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h402081B3};
    set_f(tbl[0]);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (m_count == D) restart();
      set_f(tbl[i]);
      step(0, 0, 0, 1, tbl[i].w);
    end
    restart();
    for (int i = 0; i < 6; i++) begin
      rnd_fields(5);
      imm = 0;
      step(0, 0, 0, 1, enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
    end
    restart();
    set_f(tbl[5]);
    step(0, 0, 0, 1, tbl[5].w);
    set_f(tbl[7]);
    step(0, 1, 1, 1, tbl[7].w);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    set_f(tbl[0]);
    step(0, 0, 0, 1, tbl[0].w);
    step(1, 0, 0, 1, tbl[0].w);
    step(0, 0, 0, 1, tbl[0].w);
`ifdef IMM_RANGE_CHECK_EN
    step(0, 1, 0, 0, 0);
    set_f(tbl[0]);
    imm = 32'd3;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    restart();
`endif
    for (int i = 0; i < 400; i++) begin
      rnd_fields(7);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
